seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_if.sv | 39 +++
 rtl/seq_multiplier.sv | 154 +++++++++++++++
 tb/tb_seq_multiplier.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake/operand bundle between the calculator datapath and seq_multiplier.
// Optional feature macro: SEQ_MUL_SIGNED_EN (adds the sgn mode select).
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
`ifdef SEQ_MUL_SIGNED_EN
    logic                   sgn;
`endif
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
`ifdef SEQ_MUL_SIGNED_EN
        output sgn,
`endif
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
`ifdef SEQ_MUL_SIGNED_EN
        input  sgn,
`endif
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, fixed
// latency of WIDTH iterations, registered 2*WIDTH-bit product with a one-cycle
// done pulse. Optional feature macro: SEQ_MUL_SIGNED_EN (two's-complement mode
// via sgn: magnitudes taken at accept, result negated at load).
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_multiplier_if.slave   bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = 2 * WIDTH + 1;

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be in 2..16");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e               state_q, state_d;

    logic [AW-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic                 neg_q, neg_d;

    logic                 accept;
    logic                 last;
    logic                 busy;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 res_neg;
    logic [WIDTH:0]       upper_sum;
    logic [AW-1:0]        acc_step;
    logic [2*WIDTH-1:0]   result;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept in IDLE, return after the final iteration
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and control strobes
    always_comb begin
        busy        = (state_q == RUN);
        accept      = (state_q == IDLE) && bus.start;
        last        = (state_q == RUN) && (cnt_q == CW'(1));
        bus.busy    = busy;
        bus.done    = done_q;
        bus.product = product_q;
    end

    // Operand conditioning at accept: magnitudes plus result sign in signed mode
    always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
        logic a_neg;
        logic b_neg;
        a_neg   = bus.sgn & bus.multiplicand[WIDTH-1];
        b_neg   = bus.sgn & bus.multiplier[WIDTH-1];
        // -(most negative) wraps to the same bit pattern, which read unsigned
        // is exactly its magnitude, so no extra bit is needed.
        mag_a   = a_neg ? (WIDTH'(0) - bus.multiplicand) : bus.multiplicand;
        mag_b   = b_neg ? (WIDTH'(0) - bus.multiplier)   : bus.multiplier;
        res_neg = a_neg ^ b_neg;
`else
        mag_a   = bus.multiplicand;
        mag_b   = bus.multiplier;
        res_neg = 1'b0;
`endif
    end

    // One shift-and-add iteration; the accumulator MSB is always zero before
    // the add, so the upper-half sum cannot overflow its WIDTH+1 bits
    always_comb begin
        upper_sum = acc_q[AW-1:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
`ifdef SEQ_MUL_SIGNED_EN
        result    = neg_q ? ((2*WIDTH)'(0) - acc_step[2*WIDTH-1:0])
                          : acc_step[2*WIDTH-1:0];
`else
        result    = acc_step[2*WIDTH-1:0];
`endif
    end

    // Datapath next-state: load on accept, iterate while running, publish on last
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        if (accept) begin
            acc_d    = '0;
            mcand_d  = mag_a;
            mplier_d = mag_b;
            cnt_d    = CW'(WIDTH);
            neg_d    = res_neg;
        end else if (busy) begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (last) begin
                product_d = result;
                done_d    = 1'b1;
            end
        end
    end

    // Datapath registers; reset also discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Signed vectors run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  hold4;

    seq_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge where done is high.
    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp);
        bus4.start        = 1'b1;
        bus4.multiplicand = a;
        bus4.multiplier   = b;
        @(negedge clk);
        bus4.start        = 1'b0;
        bus4.multiplicand = ~a;
        bus4.multiplier   = ~b;
        check({tag, "/busy1"}, 16'(bus4.busy), 16'd1);
        check({tag, "/done1"}, 16'(bus4.done), 16'd0);
        check({tag, "/hold1"}, 16'(bus4.product), 16'(hold4));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check({tag, "/busy"}, 16'(bus4.busy), 16'd1);
            check({tag, "/done"}, 16'(bus4.done), 16'd0);
            check({tag, "/hold"}, 16'(bus4.product), 16'(hold4));
        end
        @(negedge clk);
        check({tag, "/busy_end"}, 16'(bus4.busy), 16'd0);
        check({tag, "/done_end"}, 16'(bus4.done), 16'd1);
        check({tag, "/product"}, 16'(bus4.product), 16'(exp));
        hold4 = exp;
    endtask

    initial begin
        rst               = 1'b1;
        hold4             = 8'h00;
        bus4.start        = 1'b0;
        bus4.multiplicand = '0;
        bus4.multiplier   = '0;
        bus8.start        = 1'b0;
        bus8.multiplicand = '0;
        bus8.multiplier   = '0;
`ifdef SEQ_MUL_SIGNED_EN
        bus4.sgn          = 1'b0;
        bus8.sgn          = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst/busy", 16'(bus4.busy), 16'd0);
        check("rst/done", 16'(bus4.done), 16'd0);
        check("rst/product", 16'(bus4.product), 16'd0);
        check("rst/product8", bus8.product, 16'd0);
        rst = 1'b0;

        // 10 x 11 = 110, held after done drops
        op4("t1", 4'b1010, 4'b1011, 8'h6E);
        @(negedge clk);
        check("t1/done_drop", 16'(bus4.done), 16'd0);
        check("t1/held", 16'(bus4.product), 16'h006E);

        // 15 x 15, then restart on the done cycle with 0 x 9
        op4("t2a", 4'd15, 4'd15, 8'hE1);
        op4("t2b", 4'd0, 4'd9, 8'h00);

        // 3 x 5 with a 7 x 7 request during RUN that must be ignored
        bus4.start = 1'b1; bus4.multiplicand = 4'd3; bus4.multiplier = 4'd5;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.multiplicand = 4'd7; bus4.multiplier = 4'd7;
        @(negedge clk);
        bus4.start = 1'b0;
        check("t3/busy2", 16'(bus4.busy), 16'd1);
        @(negedge clk);
        check("t3/busy3", 16'(bus4.busy), 16'd1);
        check("t3/done3", 16'(bus4.done), 16'd0);
        @(negedge clk);
        check("t3/done", 16'(bus4.done), 16'd1);
        check("t3/product", 16'(bus4.product), 16'h000F);
        hold4 = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3/no_second_done", 16'(bus4.done), 16'd0);
            check("t3/no_queue", 16'(bus4.busy), 16'd0);
            check("t3/held", 16'(bus4.product), 16'h000F);
        end

        // 12 x 12 aborted by reset on cycle 2 of RUN
        bus4.start = 1'b1; bus4.multiplicand = 4'd12; bus4.multiplier = 4'd12;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4/busy", 16'(bus4.busy), 16'd0);
        check("t4/done", 16'(bus4.done), 16'd0);
        check("t4/product", 16'(bus4.product), 16'd0);
        hold4 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4/no_done", 16'(bus4.done), 16'd0);
            check("t4/idle", 16'(bus4.busy), 16'd0);
        end
        op4("t4b", 4'd2, 4'd3, 8'h06);

        // -8 bit pattern times 7 in unsigned mode: 8 x 7 = 56
        op4("t6", 4'b1000, 4'b0111, 8'h38);

        // WIDTH=8: 255 x 255
        @(negedge clk);
        bus8.start = 1'b1; bus8.multiplicand = 8'd255; bus8.multiplier = 8'd255;
        @(negedge clk);
        bus8.start = 1'b0; bus8.multiplicand = 8'd0; bus8.multiplier = 8'd0;
        check("t5/busy_first", 16'(bus8.busy), 16'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("t5/busy", 16'(bus8.busy), 16'd1);
            check("t5/done", 16'(bus8.done), 16'd0);
        end
        @(negedge clk);
        check("t5/done_end", 16'(bus8.done), 16'd1);
        check("t5/busy_end", 16'(bus8.busy), 16'd0);
        check("t5/product", bus8.product, 16'hFE01);
        @(negedge clk);
        check("t5/done_drop", 16'(bus8.done), 16'd0);
        check("t5/held", bus8.product, 16'hFE01);

`ifdef SEQ_MUL_SIGNED_EN
        bus4.sgn = 1'b1;
        op4("s1", 4'b1010, 4'b1011, 8'h1E);
        op4("s2", 4'b1000, 4'b0111, 8'hC8);
        op4("s3", 4'b1000, 4'b1000, 8'h40);
        bus4.sgn = 1'b0;
        op4("s4", 4'b1010, 4'b1011, 8'h6E);
        op4("s5", 4'b1000, 4'b0111, 8'h38);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
